hpdcache_victim_sel_ext: RTL and testbench

Next-generation victim selector for the HPDcache miss/refill path. It supports random and bit-PLRU policies for any SETS/WAYS and adds per-request way locking. It excludes ways with a pending fetch, prefers clean ways to avoid writebacks, and delivers a registered victim with a valid flag and a "no candidate" indication. It sits between the directory lookup stage and the refill/miss handler.

---
 rtl/hpdcache_pkg.sv | 38 +++
 rtl/hpdcache_victim_sel_ext_if.sv | 46 ++++
 rtl/hpdcache_victim_rot_pick.sv | 36 +++
 rtl/hpdcache_victim_sel_ext.sv | 169 ++++++++++++++++
 tb/tb_hpdcache_victim_sel_ext.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/hpdcache_pkg.sv
// rtl/hpdcache_pkg.sv - shared HPDcache victim-selection types, constants and LFSR tap helper
//
// Purpose: the replacement-policy enum, the default LFSR width, and the
//          feedback-tap table for the Galois LFSR used by the random policy.
// Ports:   none (package).
package hpdcache_pkg;

    typedef enum logic [1:0] {
        HPDCACHE_VICTIM_RANDOM = 2'd0,
        HPDCACHE_VICTIM_PLRU   = 2'd1
    } hpdcache_victim_sel_policy_e;

    localparam int HPDCACHE_VICTIM_LFSR_W_DEFAULT = 8;

    // Right-shifting Galois feedback masks for maximal-length sequences.
    // Any width without an entry falls back to MSB-only feedback, which is a
    // plain rotation: not maximal, but it still never reaches zero.
    function automatic logic [31:0] hpdcache_victim_lfsr_taps(input int unsigned width);
        case (width)
            3:       return 32'h0000_0006;
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            9:       return 32'h0000_0110;
            10:      return 32'h0000_0240;
            11:      return 32'h0000_0500;
            12:      return 32'h0000_0829;
            13:      return 32'h0000_100D;
            14:      return 32'h0000_2015;
            15:      return 32'h0000_6000;
            16:      return 32'h0000_D008;
            default: return 32'h1 << (width - 1);
        endcase
    endfunction

endpackage

// File: rtl/hpdcache_victim_sel_ext_if.sv
// rtl/hpdcache_victim_sel_ext_if.sv - request/update/result bundle of the victim selector
//
// Purpose: groups the replacement-state updates, the victim request with its
//          per-way directory view, and the registered victim result.
// Ports:   master drives updates and requests and receives the result;
//          slave is the selector itself.
interface hpdcache_victim_sel_ext_if #(
    parameter int SETS = 64,
    parameter int WAYS = 4
);
    localparam int SET_W = (SETS > 1) ? $clog2(SETS) : 1;

    logic              updt_i;
    logic [SET_W-1:0]  updt_set_i;
    logic [WAYS-1:0]   updt_way_i;
    logic              repl_i;
    logic [SET_W-1:0]  repl_set_i;
    logic [WAYS-1:0]   repl_way_i;
    logic              sel_victim_i;
    logic [SET_W-1:0]  sel_set_i;
    logic [WAYS-1:0]   sel_dir_valid_i;
    logic [WAYS-1:0]   sel_dir_wback_i;
    logic [WAYS-1:0]   sel_dir_dirty_i;
    logic [WAYS-1:0]   sel_dir_fetch_i;
    logic [WAYS-1:0]   sel_lock_i;
    logic              sel_victim_valid_o;
    logic [WAYS-1:0]   sel_victim_way_o;
    logic              sel_victim_none_o;

    modport master (
        output updt_i, updt_set_i, updt_way_i,
        output repl_i, repl_set_i, repl_way_i,
        output sel_victim_i, sel_set_i, sel_dir_valid_i, sel_dir_wback_i,
        output sel_dir_dirty_i, sel_dir_fetch_i, sel_lock_i,
        input  sel_victim_valid_o, sel_victim_way_o, sel_victim_none_o
    );

    modport slave (
        input  updt_i, updt_set_i, updt_way_i,
        input  repl_i, repl_set_i, repl_way_i,
        input  sel_victim_i, sel_set_i, sel_dir_valid_i, sel_dir_wback_i,
        input  sel_dir_dirty_i, sel_dir_fetch_i, sel_lock_i,
        output sel_victim_valid_o, sel_victim_way_o, sel_victim_none_o
    );

endinterface

// File: rtl/hpdcache_victim_rot_pick.sv
// rtl/hpdcache_victim_rot_pick.sv - rotating first-one finder
//
// Purpose: returns a one-hot of the first set bit of mask_i at index >=
//          start_i, wrapping past the top way back to way 0; zero if mask_i
//          is empty.
// Ports:   mask_i  candidate ways
//          start_i first index to consider
//          pick_o  one-hot pick (or zero)
module hpdcache_victim_rot_pick
    import hpdcache_pkg::*;
#(
    parameter int WAYS  = 4,
    parameter int IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
    input  logic [WAYS-1:0]  mask_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [WAYS-1:0]  pick_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        pick_o = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < WAYS; k++) begin
            idx = IDX_W'((int'(start_i) + k) % WAYS);
            if (!found && mask_i[idx]) begin
                pick_o[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hpdcache_victim_sel_ext.sv
// rtl/hpdcache_victim_sel_ext.sv - HPDcache victim selector with locking, fetch exclusion and dirty avoidance
//
// Purpose: picks a refill victim per request, one cycle after the request.
//          Invalid eligible ways win outright; otherwise clean ways are
//          preferred (AVOID_DIRTY) and the random or bit-PLRU policy chooses.
// Ports:   clk_i, rst_i  clock and asynchronous active-high reset
//          victim_if     slave side of hpdcache_victim_sel_ext_if
//                        (updt/repl state updates, request, registered result)
module hpdcache_victim_sel_ext
    import hpdcache_pkg::*;
#(
    parameter int                          SETS        = 64,
    parameter int                          WAYS        = 4,
    parameter hpdcache_victim_sel_policy_e POLICY      = HPDCACHE_VICTIM_PLRU,
    parameter bit                          AVOID_DIRTY = 1'b1,
    parameter int                          LFSR_W      = HPDCACHE_VICTIM_LFSR_W_DEFAULT,
    parameter logic [LFSR_W-1:0]           LFSR_SEED   = LFSR_W'(8'h5A)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    hpdcache_victim_sel_ext_if.slave  victim_if
);

    localparam int                SET_W     = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int                WAY_IDX_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam logic [LFSR_W-1:0] LFSR_TAPS = LFSR_W'(hpdcache_victim_lfsr_taps(LFSR_W));
    localparam bit                USE_PLRU  = (POLICY == HPDCACHE_VICTIM_PLRU) && (WAYS > 1);
    localparam bit                USE_RAND  = (POLICY == HPDCACHE_VICTIM_RANDOM) && (WAYS > 1);

    logic [WAYS-1:0]      cand;
    logic [WAYS-1:0]      inv_cand;
    logic [WAYS-1:0]      clean;
    logic [WAYS-1:0]      pol_mask;
    logic [WAYS-1:0]      plru_free;
    logic [WAYS-1:0]      pick_mask;
    logic [WAY_IDX_W-1:0] pick_start;
    logic [WAY_IDX_W-1:0] rand_start;
    logic [LFSR_W-1:0]    lfsr_mod;
    logic [WAYS-1:0]      pick_way;
    logic [WAYS-1:0]      mru_rd;
    logic                 lfsr_shift;

    logic                 valid_d, valid_q;
    logic [WAYS-1:0]      way_d, way_q;
    logic                 none_d, none_q;
    logic [LFSR_W-1:0]    lfsr_d, lfsr_q;

    // OR-in the touched ways; once every way is marked, keep only the ones
    // just touched so the set never becomes "all recently used".
    function automatic logic [WAYS-1:0] mru_merge(input logic [WAYS-1:0] old_bits,
                                                  input logic [WAYS-1:0] touch);
        logic [WAYS-1:0] merged;
        merged = old_bits | touch;
        return (&merged) ? touch : merged;
    endfunction

    assign lfsr_mod   = lfsr_q % LFSR_W'(WAYS);
    assign rand_start = WAY_IDX_W'(lfsr_mod);
    assign plru_free  = pol_mask & ~mru_rd;

    always_comb begin
        cand       = ~victim_if.sel_lock_i & ~victim_if.sel_dir_fetch_i;
        inv_cand   = cand & ~victim_if.sel_dir_valid_i;
        clean      = cand & ~(victim_if.sel_dir_wback_i & victim_if.sel_dir_dirty_i);
        pol_mask   = (AVOID_DIRTY && (|clean)) ? clean : cand;
        pick_mask  = pol_mask;
        pick_start = '0;
        if (|inv_cand) begin
            pick_mask = inv_cand;
        end else if (USE_PLRU) begin
            pick_mask = (|plru_free) ? plru_free : pol_mask;
        end else if (USE_RAND) begin
            pick_start = rand_start;
        end
    end

    hpdcache_victim_rot_pick #(
        .WAYS  (WAYS),
        .IDX_W (WAY_IDX_W)
    ) u_rot_pick (
        .mask_i  (pick_mask),
        .start_i (pick_start),
        .pick_o  (pick_way)
    );

    // The LFSR only advances when the policy actually made a choice.
    assign lfsr_shift = USE_RAND && victim_if.sel_victim_i && !(|inv_cand) && (|cand);

    always_comb begin
        valid_d = victim_if.sel_victim_i;
        way_d   = way_q;
        none_d  = none_q;
        lfsr_d  = lfsr_q;
        if (victim_if.sel_victim_i) begin
            way_d  = pick_way;
            none_d = ~(|cand);
        end
        if (lfsr_shift) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            way_q   <= '0;
            none_q  <= 1'b0;
            lfsr_q  <= LFSR_SEED;
        end else begin
            valid_q <= valid_d;
            way_q   <= way_d;
            none_q  <= none_d;
            lfsr_q  <= lfsr_d;
        end
    end

    generate
        if (USE_PLRU) begin : gen_plru
            logic [WAYS-1:0] mru_q [SETS];
            logic [WAYS-1:0] mru_d [SETS];

            // Read before the same-cycle update lands.
            assign mru_rd = mru_q[victim_if.sel_set_i];

            always_comb begin
                for (int s = 0; s < SETS; s++) begin
                    mru_d[s] = mru_merge(mru_q[s],
                        ({WAYS{victim_if.updt_i && (victim_if.updt_set_i == SET_W'(s))}}
                            & victim_if.updt_way_i) |
                        ({WAYS{victim_if.repl_i && (victim_if.repl_set_i == SET_W'(s))}}
                            & victim_if.repl_way_i));
                end
            end

            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int s = 0; s < SETS; s++) begin
                        mru_q[s] <= '0;
                    end
                end else begin
                    for (int s = 0; s < SETS; s++) begin
                        mru_q[s] <= mru_d[s];
                    end
                end
            end
        end else begin : gen_no_plru
            logic unused_updt;
            assign unused_updt = ^{victim_if.updt_i, victim_if.updt_set_i, victim_if.updt_way_i,
                                   victim_if.repl_i, victim_if.repl_set_i, victim_if.repl_way_i,
                                   victim_if.sel_set_i};
            assign mru_rd = '0;
        end
    endgenerate

    assign victim_if.sel_victim_valid_o = valid_q;
    assign victim_if.sel_victim_way_o   = way_q;
    assign victim_if.sel_victim_none_o  = none_q;

`ifndef SYNTHESIS
    a_policy_legal: assert property (@(posedge clk_i)
        (POLICY == HPDCACHE_VICTIM_RANDOM) || (POLICY == HPDCACHE_VICTIM_PLRU));
    a_seed_nonzero: assert property (@(posedge clk_i) LFSR_SEED != '0);
    a_way_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        victim_if.sel_victim_valid_o |-> $onehot0(victim_if.sel_victim_way_o));
    a_way_eligible: assert property (@(posedge clk_i) disable iff (rst_i)
        victim_if.sel_victim_i |-> ((pick_way & ~cand) == '0));
`endif

endmodule

// File: tb/tb_hpdcache_victim_sel_ext.sv
// tb/tb_hpdcache_victim_sel_ext.sv - directed self-checking bench for hpdcache_victim_sel_ext
module tb_hpdcache_victim_sel_ext;
    import hpdcache_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       updt = 1'b0;
    logic [5:0] updt_set = '0;
    logic [3:0] updt_way = '0;
    logic       repl = 1'b0;
    logic [5:0] repl_set = '0;
    logic [3:0] repl_way = '0;
    logic       sel_p = 1'b0;
    logic       sel_r = 1'b0;
    logic [5:0] sel_set = '0;
    logic [3:0] dir_valid = 4'b1111;
    logic [3:0] dir_wback = '0;
    logic [3:0] dir_dirty = '0;
    logic [3:0] dir_fetch = '0;
    logic [3:0] lock = '0;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] lfsr_m;
    logic [3:0] exp_way;
    logic [3:0] lock_tab [8];

    always #5 clk = ~clk;

    hpdcache_victim_sel_ext_if #(.SETS(64), .WAYS(4)) p_if ();
    hpdcache_victim_sel_ext_if #(.SETS(64), .WAYS(4)) r_if ();

    assign p_if.updt_i = updt;          assign r_if.updt_i = updt;
    assign p_if.updt_set_i = updt_set;  assign r_if.updt_set_i = updt_set;
    assign p_if.updt_way_i = updt_way;  assign r_if.updt_way_i = updt_way;
    assign p_if.repl_i = repl;          assign r_if.repl_i = repl;
    assign p_if.repl_set_i = repl_set;  assign r_if.repl_set_i = repl_set;
    assign p_if.repl_way_i = repl_way;  assign r_if.repl_way_i = repl_way;
    assign p_if.sel_victim_i = sel_p;   assign r_if.sel_victim_i = sel_r;
    assign p_if.sel_set_i = sel_set;    assign r_if.sel_set_i = sel_set;
    assign p_if.sel_dir_valid_i = dir_valid; assign r_if.sel_dir_valid_i = dir_valid;
    assign p_if.sel_dir_wback_i = dir_wback; assign r_if.sel_dir_wback_i = dir_wback;
    assign p_if.sel_dir_dirty_i = dir_dirty; assign r_if.sel_dir_dirty_i = dir_dirty;
    assign p_if.sel_dir_fetch_i = dir_fetch; assign r_if.sel_dir_fetch_i = dir_fetch;
    assign p_if.sel_lock_i = lock;      assign r_if.sel_lock_i = lock;

    hpdcache_victim_sel_ext #(
        .SETS(64), .WAYS(4), .POLICY(HPDCACHE_VICTIM_PLRU),
        .AVOID_DIRTY(1'b1), .LFSR_W(8), .LFSR_SEED(8'h5A)
    ) dut_p (
        .clk_i(clk), .rst_i(rst), .victim_if(p_if)
    );

    hpdcache_victim_sel_ext #(
        .SETS(64), .WAYS(4), .POLICY(HPDCACHE_VICTIM_RANDOM),
        .AVOID_DIRTY(1'b1), .LFSR_W(8), .LFSR_SEED(8'h5A)
    ) dut_r (
        .clk_i(clk), .rst_i(rst), .victim_if(r_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
    endfunction

    function automatic logic [3:0] rand_ref(input logic [7:0] l, input logic [3:0] c);
        int st;
        int idx;
        logic [3:0] r;
        st = int'(l % 8'd4);
        r = '0;
        for (int k = 0; k < 4; k++) begin
            idx = (st + k) % 4;
            if (r == 4'b0000 && c[idx]) r[idx] = 1'b1;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic req_p(input logic [5:0] s, input logic [3:0] v, input logic [3:0] wb,
                         input logic [3:0] dt, input logic [3:0] fe, input logic [3:0] lk);
        sel_set = s; dir_valid = v; dir_wback = wb; dir_dirty = dt; dir_fetch = fe; lock = lk;
        sel_p = 1'b1;
        step();
        sel_p = 1'b0;
    endtask

    task automatic updt_p(input logic [5:0] s, input logic [3:0] w);
        updt = 1'b1; updt_set = s; updt_way = w;
        step();
        updt = 1'b0;
    endtask

    initial begin
        lock_tab = '{4'b0000, 4'b1000, 4'b0100, 4'b1100, 4'b0001, 4'b0110, 4'b1001, 4'b0011};

        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", p_if.sel_victim_valid_o, 1'b0);
        check("rst_way", p_if.sel_victim_way_o, 4'b0000);
        check("rst_none", p_if.sel_victim_none_o, 1'b0);
        check("rst_lfsr", dut_r.lfsr_q, 8'h5A);
        rst = 1'b0;

        // 1: lowest invalid candidate wins, LFSR untouched
        sel_r = 1'b1;
        req_p(6'd3, 4'b1011, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        sel_r = 1'b0;
        check("t1_valid", p_if.sel_victim_valid_o, 1'b1);
        check("t1_way", p_if.sel_victim_way_o, 4'b0100);
        check("t1_none", p_if.sel_victim_none_o, 1'b0);
        check("t1_rnd_way", r_if.sel_victim_way_o, 4'b0100);
        check("t1_lfsr", dut_r.lfsr_q, 8'h5A);
        step();
        check("t1_valid_drop", p_if.sel_victim_valid_o, 1'b0);
        check("t1_way_hold", p_if.sel_victim_way_o, 4'b0100);

        // 2: PLRU fill then saturation clear
        updt_p(6'd5, 4'b0001);
        updt_p(6'd5, 4'b0010);
        updt_p(6'd5, 4'b0100);
        req_p(6'd5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        check("t2_way3", p_if.sel_victim_way_o, 4'b1000);
        updt_p(6'd5, 4'b1000);
        req_p(6'd5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        check("t2_way0", p_if.sel_victim_way_o, 4'b0001);
        req_p(6'd5, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        check("t2_lock0", p_if.sel_victim_way_o, 4'b0010);

        // 3: clean preferred, then fall back to dirty set
        req_p(6'd7, 4'b1111, 4'b1111, 4'b1101, 4'b0000, 4'b0000);
        check("t3_clean", p_if.sel_victim_way_o, 4'b0010);
        req_p(6'd7, 4'b1111, 4'b1111, 4'b1101, 4'b0000, 4'b0010);
        check("t3_dirty", p_if.sel_victim_way_o, 4'b0001);
        req_p(6'd7, 4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b0000);
        check("t3_no_wback", p_if.sel_victim_way_o, 4'b0001);

        // 4: nothing eligible
        req_p(6'd9, 4'b1111, 4'b0000, 4'b0000, 4'b1010, 4'b0101);
        check("t4_valid", p_if.sel_victim_valid_o, 1'b1);
        check("t4_way", p_if.sel_victim_way_o, 4'b0000);
        check("t4_none", p_if.sel_victim_none_o, 1'b1);
        step();
        check("t4_none_hold", p_if.sel_victim_none_o, 1'b1);
        check("t4_valid_drop", p_if.sel_victim_valid_o, 1'b0);

        // 5: same-cycle updt+repl+request, and independent sets in one cycle
        updt = 1'b1; updt_set = 6'd2; updt_way = 4'b0010;
        repl = 1'b1; repl_set = 6'd2; repl_way = 4'b1000;
        req_p(6'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        updt = 1'b0; repl = 1'b0;
        check("t5_old_state", p_if.sel_victim_way_o, 4'b0001);
        req_p(6'd2, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        check("t5_mru_1010", p_if.sel_victim_way_o, 4'b0100);
        updt = 1'b1; updt_set = 6'd10; updt_way = 4'b0001;
        repl = 1'b1; repl_set = 6'd11; repl_way = 4'b0010;
        step();
        updt = 1'b0; repl = 1'b0;
        req_p(6'd10, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        check("t5_set10", p_if.sel_victim_way_o, 4'b0010);
        req_p(6'd11, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        check("t5_set11", p_if.sel_victim_way_o, 4'b0001);

        // 6: random policy, back-to-back requests against the LFSR model
        lfsr_m = 8'h5A;
        dir_valid = 4'b1111; dir_wback = '0; dir_dirty = '0; dir_fetch = '0;
        sel_set = 6'd0;
        for (int i = 0; i < 8; i++) begin
            lock = lock_tab[i];
            exp_way = rand_ref(lfsr_m, ~lock_tab[i]);
            sel_r = 1'b1;
            step();
            check("t6_way", r_if.sel_victim_way_o, exp_way);
            check("t6_valid", r_if.sel_victim_valid_o, 1'b1);
            lfsr_m = lfsr_step(lfsr_m);
        end
        sel_r = 1'b0;
        lock = '0;
        check("t6_lfsr8", dut_r.lfsr_q, lfsr_m);
        for (int i = 0; i < 4; i++) begin
            exp_way = rand_ref(lfsr_m, 4'b1111);
            sel_r = 1'b1;
            step();
            check("t6b_way", r_if.sel_victim_way_o, exp_way);
            lfsr_m = lfsr_step(lfsr_m);
        end
        rst = 1'b1;
        step();
        sel_r = 1'b0;
        check("t6_rst_valid", r_if.sel_victim_valid_o, 1'b0);
        check("t6_rst_lfsr", dut_r.lfsr_q, 8'h5A);
        check("t6_rst_way", r_if.sel_victim_way_o, 4'b0000);
        rst = 1'b0;
        lfsr_m = 8'h5A;
        sel_r = 1'b1;
        step();
        sel_r = 1'b0;
        check("t6_after_rst", r_if.sel_victim_way_o, rand_ref(lfsr_m, 4'b1111));
        check("t6_after_lfsr", dut_r.lfsr_q, lfsr_step(lfsr_m));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
